ps2_cmd_sequencer: RTL and testbench

//  Host-side command controller for the PS/2 keyboard port. It shares the

---
 rtl/ps2_cmd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: shares the keyboard link between scancode
// forwarding and the reset / set-LED command sequences (ACK, resend, timeouts).
module ps2_cmd_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 500000,
    parameter int unsigned BAT_TIMEOUT = 25000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reset_req,
    input  logic       led_req,
    input  logic [2:0] led_state,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       enable_rcv,
    output logic [7:0] key_data,
    output logic       key_valid
);

    localparam int unsigned TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] BAT_LAST    = CW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_RETRY,
        ST_FINISH,
        ST_FAIL
    } state_t;

    state_t        state, state_n;
    logic          pend_rst, pend_led;
    logic [2:0]    led_mask;
    logic          cmd_rst, cmd_rst_n;
    logic [2:0]    cmd_mask, cmd_mask_n;
    logic          idx, idx_n;
    logic [RW-1:0] retry, retry_n;
    logic [CW-1:0] timer, timer_n;
    logic          take_rst, take_led;
    logic [7:0]    send_byte;
    logic          rx_ok, rx_is_resp, rx_fwd;

    assign tx_req     = (state == ST_SEND);
    assign done       = (state == ST_FINISH);
    assign err        = (state == ST_FAIL);
    assign enable_rcv = !((state == ST_SEND) || (state == ST_WAIT_TX));
    assign busy       = pend_rst | pend_led | (state != ST_IDLE);

    assign rx_ok      = rx_valid & enable_rcv;
    assign rx_is_resp = (rx_data == RSP_ACK) || (rx_data == RSP_RESEND) ||
                        (rx_data == RSP_BAT_OK) || (rx_data == RSP_BAT_FAIL);
    assign rx_fwd     = rx_ok && ((state == ST_IDLE) ||
                        (((state == ST_WAIT_ACK) || (state == ST_WAIT_BAT)) && !rx_is_resp));

    always_comb begin
        state_n    = state;
        cmd_rst_n  = cmd_rst;
        cmd_mask_n = cmd_mask;
        idx_n      = idx;
        retry_n    = retry;
        timer_n    = timer;
        take_rst   = 1'b0;
        take_led   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pend_rst) begin
                    take_rst  = 1'b1;
                    cmd_rst_n = 1'b1;
                    idx_n     = 1'b0;
                    retry_n   = '0;
                    state_n   = ST_SEND;
                end else if (pend_led) begin
                    // mask is frozen per command so a newer led_req only affects the next one
                    take_led   = 1'b1;
                    cmd_rst_n  = 1'b0;
                    cmd_mask_n = led_mask;
                    idx_n      = 1'b0;
                    retry_n    = '0;
                    state_n    = ST_SEND;
                end
            end

            ST_SEND: state_n = ST_WAIT_TX;

            ST_WAIT_TX: begin
                if (tx_done) begin
                    timer_n = '0;
                    state_n = ST_WAIT_ACK;
                end else if (tx_err) begin
                    state_n = ST_RETRY;
                end
            end

            ST_WAIT_ACK: begin
                if (rx_ok && (rx_data == RSP_ACK)) begin
                    if (cmd_rst) begin
                        timer_n = '0;
                        state_n = ST_WAIT_BAT;
                    end else if (idx) begin
                        state_n = ST_FINISH;
                    end else begin
                        idx_n   = 1'b1;
                        retry_n = '0;
                        state_n = ST_SEND;
                    end
                end else if (rx_ok && (rx_data == RSP_RESEND)) begin
                    state_n = ST_RETRY;
                end else if (timer == ACK_LAST) begin
                    state_n = ST_FAIL;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end

            ST_WAIT_BAT: begin
                if (rx_ok && (rx_data == RSP_BAT_OK)) begin
                    state_n = ST_FINISH;
                end else if (rx_ok && (rx_data == RSP_BAT_FAIL)) begin
                    state_n = ST_FAIL;
                end else if (timer == BAT_LAST) begin
                    state_n = ST_FAIL;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end

            ST_RETRY: begin
                if (retry == RETRY_LIMIT) begin
                    state_n = ST_FAIL;
                end else begin
                    retry_n = retry + RW'(1);
                    state_n = ST_SEND;
                end
            end

            ST_FINISH: state_n = ST_IDLE;
            ST_FAIL:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        if (cmd_rst_n)
            send_byte = CMD_RESET;
        else if (idx_n)
            send_byte = {5'b0, cmd_mask_n};
        else
            send_byte = CMD_SET_LED;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rst  <= 1'b0;
            pend_led  <= 1'b0;
            led_mask  <= '0;
            cmd_rst   <= 1'b0;
            cmd_mask  <= '0;
            idx       <= 1'b0;
            retry     <= '0;
            timer     <= '0;
            tx_data   <= '0;
            key_data  <= '0;
            key_valid <= 1'b0;
        end else begin
            // a request arriving while its flag is being consumed stays pending
            pend_rst <= reset_req | (pend_rst & ~take_rst);
            pend_led <= led_req | (pend_led & ~take_led);
            if (led_req)
                led_mask <= led_state;
            cmd_rst  <= cmd_rst_n;
            cmd_mask <= cmd_mask_n;
            idx      <= idx_n;
            retry    <= retry_n;
            timer    <= timer_n;
            if (state_n == ST_SEND)
                tx_data <= send_byte;
            key_valid <= rx_fwd;
            if (rx_fwd)
                key_data <= rx_data;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: acts as the keyboard/transmitter and checks the
// command byte stream and outcomes against a transaction-level model.
module tb_ps2_cmd_sequencer;

    localparam int unsigned ACK_TO    = 100;
    localparam int unsigned BAT_TO    = 300;
    localparam int unsigned MAX_RETRY = 3;

    // device behaviour codes after a command byte
    localparam int B_ACK = 0, B_RESEND = 1, B_TXERR = 2, B_SILENT = 3;
    // device behaviour codes after the reset ACK
    localparam int T_AA = 0, T_FC = 1, T_SILENT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset_req = 1'b0, led_req = 1'b0;
    logic [2:0] led_state = '0;
    logic       busy, done, err;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_done = 1'b0, tx_err = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       enable_rcv;
    logic [7:0] key_data;
    logic       key_valid;

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned done_seen = 0, err_seen = 0, key_seen = 0;
    int unsigned exp_done = 0, exp_err = 0, exp_key = 0;
    int          script[$];

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT(ACK_TO),
        .BAT_TIMEOUT(BAT_TO),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reset_req (reset_req),
        .led_req   (led_req),
        .led_state (led_state),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .enable_rcv(enable_rcv),
        .key_data  (key_data),
        .key_valid (key_valid)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (done)      done_seen++;
        if (err)       err_seen++;
        if (key_valid) key_seen++;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_scan();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hFA || b == 8'hFE || b == 8'hAA || b == 8'hFC);
        return b;
    endfunction

    function automatic int next_ack_beh();
        int unsigned r;
        if (script.size() > 0) return script.pop_front();
        r = $urandom_range(0, 99);
        if (r < 60) return B_ACK;
        if (r < 76) return B_RESEND;
        if (r < 93) return B_TXERR;
        return B_SILENT;
    endfunction

    function automatic int next_bat_beh();
        int unsigned r;
        if (script.size() > 0) return script.pop_front();
        r = $urandom_range(0, 99);
        if (r < 75) return T_AA;
        if (r < 90) return T_FC;
        return T_SILENT;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_req"},     tx_req, 0);
        check({tag, "_tx_data"},    tx_data, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_err"},        err, 0);
        check({tag, "_key_valid"},  key_valid, 0);
        check({tag, "_key_data"},   key_data, 0);
        check({tag, "_enable_rcv"}, enable_rcv, 1);
    endtask

    task automatic inject_key(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("key_valid", key_valid, 1);
        check("key_data", key_data, b);
        exp_key++;
    endtask

    task automatic send_resp(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("resp_not_forwarded", key_valid, 0);
    endtask

    task automatic wait_tx_req(output int unsigned waited, output bit seen);
        seen = 1'b0; waited = 0;
        for (int i = 0; i <= 20; i++) begin
            if (tx_req) begin
                seen = 1'b1; waited = i;
                return;
            end
            tick();
        end
    endtask

    // returns 1 for done, 2 for err, 0 if neither appears within the bound
    task automatic wait_outcome(output int unsigned kind, output int unsigned waited);
        kind = 0; waited = 0;
        for (int i = 0; i <= 6; i++) begin
            if (done || err) begin
                kind = done ? 1 : 2; waited = i;
                return;
            end
            tick();
        end
    endtask

    task automatic silent_wait(input string tag, input int unsigned limit);
        int unsigned t = 0;
        for (int i = 1; i <= int'(limit) + 5; i++) begin
            tick();
            if (err) begin t = i; break; end
            if (done) break;
        end
        check(tag, t, limit);
    endtask

    task automatic service_command(input bit is_rst, input logic [2:0] mask, input bit chk_lat);
        logic [7:0]  bytes [2];
        int unsigned nbytes, idx, retries, waited, got, exp_lat, beh;
        bit          seen, finished, expect_ok, observed;

        bytes[0] = is_rst ? 8'hFF : 8'hED;
        bytes[1] = {5'b0, mask};
        nbytes   = is_rst ? 1 : 2;
        idx = 0; retries = 0; exp_lat = 0;
        finished = 1'b0; expect_ok = 1'b0; observed = 1'b0; got = 0;

        while (!finished) begin
            wait_tx_req(waited, seen);
            check("tx_req_seen", seen, 1);
            if (!seen) return;
            if (chk_lat) begin
                check("req_to_tx_req_cycles", waited + 1, 2);
                chk_lat = 1'b0;
            end
            check("tx_data", tx_data, bytes[idx]);
            check("enable_rcv_send", enable_rcv, 0);
            tick();
            check("tx_req_one_cycle", tx_req, 0);
            check("enable_rcv_wait_tx", enable_rcv, 0);
            if ($urandom_range(0, 2) == 0) begin
                rx_data = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'($urandom_range(0, 255));
                rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
                check("rx_ignored_while_tx", key_valid, 0);
            end

            beh = next_ack_beh();
            repeat ($urandom_range(0, 2)) tick();
            if (beh == B_TXERR) begin
                tx_err = 1'b1; tick(); tx_err = 1'b0;
                if (retries == MAX_RETRY) begin finished = 1'b1; exp_lat = 1; end
                else retries++;
                continue;
            end

            tx_done = 1'b1; tick(); tx_done = 1'b0;
            if (beh == B_SILENT) begin
                silent_wait("ack_timeout_cycle", ACK_TO);
                observed = 1'b1; got = 2; finished = 1'b1;
                continue;
            end
            if ($urandom_range(0, 2) == 0) inject_key(rand_scan());
            repeat ($urandom_range(0, 3)) tick();
            if (beh == B_RESEND) begin
                send_resp(8'hFE);
                if (retries == MAX_RETRY) begin finished = 1'b1; exp_lat = 1; end
                else retries++;
                continue;
            end

            send_resp(8'hFA);
            retries = 0;
            if (is_rst) begin
                finished = 1'b1;
                beh = next_bat_beh();
                if (beh == T_SILENT) begin
                    silent_wait("bat_timeout_cycle", BAT_TO);
                    observed = 1'b1; got = 2;
                end else begin
                    if ($urandom_range(0, 2) == 0) inject_key(rand_scan());
                    repeat ($urandom_range(0, 4)) tick();
                    send_resp(beh == T_AA ? 8'hAA : 8'hFC);
                    expect_ok = (beh == T_AA);
                end
            end else if (idx == nbytes - 1) begin
                finished = 1'b1; expect_ok = 1'b1;
            end else begin
                idx++;
            end
        end

        if (!observed) begin
            wait_outcome(got, waited);
            check("outcome_latency", waited, exp_lat);
        end
        check("outcome", got, expect_ok ? 1 : 2);
        if (expect_ok) exp_done++; else exp_err++;
        tick();
        check("pulse_one_cycle", {done, err}, 0);
    endtask

    task automatic request(input bit r, input bit l, input logic [2:0] m);
        reset_req = r; led_req = l; led_state = m;
        tick();
        reset_req = 1'b0; led_req = 1'b0; led_state = 3'($urandom_range(0, 7));
        check("busy_after_req", busy, 1);
    endtask

    // kind: 0 = keyboard reset, 1 = set LEDs, 2 = both in the same cycle
    task automatic do_cmd(input int unsigned kind, input logic [2:0] m);
        request(kind != 1, kind != 0, m);
        if (kind != 1) service_command(1'b1, m, 1'b1);
        if (kind == 2) check("busy_between_cmds", busy, 1);
        if (kind != 0) service_command(1'b0, m, kind == 1);
        check("busy_idle", busy, 0);
        check("done_count", done_seen, exp_done);
        check("err_count", err_seen, exp_err);
        check("key_count", key_seen, exp_key);
    endtask

    initial begin
        int unsigned waited;
        bit          seen;
        logic        any;

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        script = '{B_ACK, B_ACK};
        do_cmd(1, 3'b101);
        script = '{B_ACK, T_AA};
        do_cmd(0, 3'b000);
        script = '{B_ACK, T_FC};
        do_cmd(0, 3'b000);
        script = '{B_RESEND, B_RESEND, B_RESEND, B_ACK, B_ACK};
        do_cmd(1, 3'b110);
        script = '{B_RESEND, B_RESEND, B_RESEND, B_RESEND};
        do_cmd(1, 3'b011);
        script = '{B_TXERR, B_TXERR, B_TXERR, B_TXERR};
        do_cmd(1, 3'b001);
        script = '{B_SILENT};
        do_cmd(1, 3'b111);
        script = '{B_ACK, T_SILENT};
        do_cmd(0, 3'b000);
        script = '{B_ACK, T_AA, B_ACK, B_ACK};
        do_cmd(2, 3'b011);

        inject_key(8'h1C);
        inject_key(8'hFA);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) inject_key(8'($urandom_range(0, 255)));
            do_cmd($urandom_range(0, 2), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) tick();
        end
        check("key_count_final", key_seen, exp_key);

        // reset in the middle of a command abandons it silently
        request(1'b0, 1'b1, 3'b010);
        wait_tx_req(waited, seen);
        check("mid_reset_tx_req_seen", seen, 1);
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        inject_key(8'h5A);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        any = 1'b0;
        for (int i = 0; i < int'(ACK_TO) + 20; i++) begin
            tick();
            any = any | tx_req | done | err | busy;
        end
        check("no_activity_after_reset", any, 0);
        check("done_count_after_reset", done_seen, exp_done);
        check("err_count_after_reset", err_seen, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
